// File: rtl/sd_read_arbiter_pkg.sv
// sd_arb_pkg: shared state encoding, default sizing and requester index type for sd_read_arbiter
package sd_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;
  localparam int SECTOR_BYTES_DEF = 512;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;
  typedef logic req_idx_t;
endpackage

// File: rtl/sd_read_arbiter_if.sv
// sd_read_arbiter_if: requester-side and SD-core-side signals of the read arbiter
//   slave  = arbiter view: req/req_addr*/sd_ready/sd_byte_avail/sd_dout in; gnt/byte_valid/byte_data/done/err/sd_rd/sd_address out
//   master = environment view (requesters + SD core), directions reversed
interface sd_read_arbiter_if;
  logic [1:0]  req;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  gnt;
  logic [1:0]  byte_valid;
  logic [7:0]  byte_data;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic        sd_ready;
  logic        sd_byte_avail;
  logic [7:0]  sd_dout;
  modport slave (
    input  req, req_addr0, req_addr1, sd_ready, sd_byte_avail, sd_dout,
    output gnt, byte_valid, byte_data, done, err, sd_rd, sd_address
  );
  modport master (
    output req, req_addr0, req_addr1, sd_ready, sd_byte_avail, sd_dout,
    input  gnt, byte_valid, byte_data, done, err, sd_rd, sd_address
  );
endinterface

// File: rtl/sd_read_arbiter_rr_picker.sv
// sd_rr_picker: combinational 2-way round-robin choice; req_i requests, ptr_i preferred index, win_o one-hot winner
module sd_rr_picker
  import sd_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   ptr_i,
  output logic [1:0] win_o
);
  assign win_o = (req_i == 2'b11) ? (ptr_i ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: shares the SD SPI core between two requesters for single-sector reads (round-robin grant, byte forwarding, done/err)
//   iCLK clock, Reset async active-low; bus = sd_read_arbiter_if.slave
//   Optional abort-on-idle timeout compiled in with SD_READ_TIMEOUT_EN (TIMEOUT_CYCLES parameter exists only then)
module sd_read_arbiter
  import sd_arb_pkg::*;
#(
  parameter int SECTOR_BYTES = SECTOR_BYTES_DEF
`ifdef SD_READ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input logic iCLK,
  input logic Reset,
  sd_read_arbiter_if.slave bus
);
  localparam int CW = $clog2(SECTOR_BYTES);
  state_t      state_q;
  req_idx_t    ptr_q;
  logic [1:0]  gnt_q, bv_q, done_q, err_q, win;
  logic [7:0]  bd_q;
  logic        rd_q;
  logic [31:0] addr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last, go_issue, go_stream, go_done, go_idle;
  sd_rr_picker u_pick (.req_i(bus.req), .ptr_i(ptr_q), .win_o(win));
  assign cnt_d     = cnt_q + 1'b1;
  assign last      = cnt_q == CW'(SECTOR_BYTES - 1);
  assign go_issue  = state_q == IDLE && |bus.req && bus.sd_ready;
  assign go_stream = state_q == ISSUE && !bus.sd_ready;
  assign go_done   = state_q == STREAM && bus.sd_byte_avail && last;
  assign go_idle   = state_q == DONE && bus.sd_ready;
`ifdef SD_READ_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        tmo_hit;
  // Abort only while waiting on the core; a strobe in the same cycle counts as progress.
  assign tmo_hit = (state_q == ISSUE || state_q == STREAM) && !bus.sd_byte_avail &&
                   tmo_q == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge iCLK or negedge Reset)
    if (!Reset) tmo_q <= '0;
    else tmo_q <= (go_issue || go_stream || go_done || go_idle || tmo_hit || bus.sd_byte_avail) ? '0 : tmo_q + 1'b1;
`endif
  always_ff @(posedge iCLK or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      bv_q    <= '0;
      bd_q    <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      bv_q   <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: if (go_issue) begin
          gnt_q   <= win;
          addr_q  <= win[1] ? bus.req_addr1 : bus.req_addr0;
          cnt_q   <= '0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          rd_q <= bus.sd_ready;
          if (go_stream) state_q <= STREAM;
        end
        STREAM: if (bus.sd_byte_avail) begin
          bv_q  <= gnt_q;
          bd_q  <= bus.sd_dout;
          cnt_q <= cnt_d;
          if (go_done) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          // gnt is still set only on the first DONE cycle; advance the pointer exactly then.
          if (|gnt_q) ptr_q <= gnt_q[0];
          gnt_q <= '0;
          if (go_idle) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef SD_READ_TIMEOUT_EN
      if (tmo_hit) begin
        rd_q    <= 1'b0;
        done_q  <= gnt_q;
        err_q   <= gnt_q;
        state_q <= DONE;
      end
`endif
    end
  assign bus.gnt        = gnt_q;
  assign bus.byte_valid = bv_q;
  assign bus.byte_data  = bd_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.sd_rd      = rd_q;
  assign bus.sd_address = addr_q;
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed + randomized checks of sd_read_arbiter against a transaction-level model
module tb_sd_read_arbiter;
  localparam int SB  = 512;
  localparam int TMO = 100;
  logic iCLK = 1'b0;
  logic Reset = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int pref = 0;
  logic [31:0] cur_a0 = '0, cur_a1 = '0;
  logic [7:0] rx0[$], rx1[$];
  int done_n[2], err_n[2], done_at[2];
  int bv_total = 0;
  sd_read_arbiter_if bus ();
  sd_read_arbiter #(
    .SECTOR_BYTES(SB)
`ifdef SD_READ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .iCLK(iCLK),
    .Reset(Reset),
    .bus(bus.slave)
  );
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge iCLK) begin
    #1;
    if (bus.byte_valid[0]) rx0.push_back(bus.byte_data);
    if (bus.byte_valid[1]) rx1.push_back(bus.byte_data);
    bv_total += $countones(bus.byte_valid);
    for (int i = 0; i < 2; i++) begin
      if (bus.done[i]) begin
        done_n[i]++;
        done_at[i] = i ? rx1.size() : rx0.size();
      end
      if (bus.err[i]) err_n[i]++;
    end
    if (bus.byte_valid != 2'b00) chk("bv_granted", bus.byte_valid & ~bus.gnt, 0);
  end
  // Called and returns on a negedge. Expected winner comes from the request set and the model's preference.
  task automatic xfer(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                      input bit incr, input int abort_at, input int stop_at, input bit drop);
    int w, n, t, nb;
    logic [1:0] oh;
    logic [7:0] b;
    logic [7:0] exp_q[$], got_q[$];
    w  = (r0 && r1) ? pref : int'(r1);
    oh = w ? 2'b10 : 2'b01;
    n  = (stop_at >= 0) ? stop_at : SB;
    rx0.delete(); rx1.delete();
    done_n = '{0, 0}; err_n = '{0, 0}; done_at = '{0, 0};
    bus.req = {r1, r0}; bus.req_addr0 = a0; bus.req_addr1 = a1; bus.sd_ready = 1'b1;
    @(negedge iCLK);
    chk("gnt", bus.gnt, oh);
    chk("sd_address", bus.sd_address, w ? a1 : a0);
    chk("rd_before", bus.sd_rd, 0);
    @(negedge iCLK);
    chk("rd_rise", bus.sd_rd, 1);
    bus.sd_ready = 1'b0;
    @(negedge iCLK);
    chk("rd_fall", bus.sd_rd, 0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat ($urandom_range(0, 2)) @(negedge iCLK);
      if (k == abort_at) begin
        Reset = 1'b0;
        #1;
        chk("abort_out", {bus.gnt, bus.byte_valid, bus.byte_data, bus.done, bus.err, bus.sd_rd, bus.sd_address}, 0);
        bus.req = 2'b00; bus.sd_byte_avail = 1'b0; bus.sd_ready = 1'b1;
        @(negedge iCLK);
        Reset = 1'b1;
        pref = 0;
        return;
      end
      if (drop && k == 100) bus.req[w] = 1'b0;
      b = incr ? k[7:0] : 8'($urandom);
      exp_q.push_back(b);
      bus.sd_byte_avail = 1'b1; bus.sd_dout = b;
      @(negedge iCLK);
      bus.sd_byte_avail = 1'b0;
    end
    if (stop_at >= 0) begin
      t = 0;
      while (bus.done == 2'b00 && t < 4 * TMO) begin
        @(negedge iCLK);
        t++;
      end
      chk("tmo_latency", t, TMO);
      chk("tmo_err", bus.err, oh);
      chk("tmo_rd", bus.sd_rd, 0);
    end else begin
      chk("done_on_last", done_at[w], SB);
      chk("err_zero", err_n[0] + err_n[1], 0);
    end
    chk("done_pulse", bus.done, oh);
    chk("gnt_hold", bus.gnt, oh);
    bus.sd_byte_avail = 1'b1;
    @(negedge iCLK);
    chk("gnt_drop", bus.gnt, 0);
    chk("done_once", done_n[w], 1);
    bus.sd_byte_avail = 1'b0; bus.sd_ready = 1'b1; bus.req[w] = 1'b0;
    @(negedge iCLK);
    chk("gnt_gap", bus.gnt, 0);
    got_q = w ? rx1 : rx0;
    chk("byte_count", got_q.size(), n);
    chk("other_bytes", w ? rx0.size() : rx1.size(), 0);
    chk("other_done", done_n[1 - w], 0);
    nb = 0;
    for (int i = 0; i < n; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nb++;
    chk("byte_data", nb, 0);
    pref = 1 - w;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int t0;
    bus.req = 2'b00; bus.req_addr0 = '0; bus.req_addr1 = '0;
    bus.sd_ready = 1'b0; bus.sd_byte_avail = 1'b0; bus.sd_dout = '0;
    repeat (2) @(negedge iCLK);
    chk("reset_out", {bus.gnt, bus.byte_valid, bus.byte_data, bus.done, bus.err, bus.sd_rd, bus.sd_address}, 0);
    Reset = 1'b1;
    @(negedge iCLK);
    cur_a0 = 32'h0000_1000; cur_a1 = 32'h0000_2000;
    xfer(1, 1, cur_a0, cur_a1, 0, -1, -1, 0);
    xfer(0, 1, cur_a0, cur_a1, 0, -1, -1, 0);
    cur_a0 = 32'h0000_0010;
    xfer(1, 0, cur_a0, cur_a1, 1, -1, -1, 0);
    cur_a1 = 32'h0000_3000;
    xfer(0, 1, cur_a0, cur_a1, 0, -1, -1, 0);
    cur_a1 = 32'h0000_3001;
    xfer(0, 1, cur_a0, cur_a1, 0, -1, -1, 1);
    t0 = bv_total;
    repeat (4) begin
      bus.sd_byte_avail = 1'b1; bus.sd_dout = 8'hA5;
      @(negedge iCLK);
      bus.sd_byte_avail = 1'b0;
      @(negedge iCLK);
    end
    chk("idle_bv", bv_total, t0);
    chk("idle_gnt", bus.gnt, 0);
    cur_a0 = 32'h0000_4000;
    xfer(1, 0, cur_a0, cur_a1, 0, 200, -1, 0);
    xfer(1, 0, cur_a0, cur_a1, 1, -1, -1, 0);
    for (int i = 0; i < 6; i++) begin
      bit r0, r1;
      r0 = bus.req[0] | 1'($urandom_range(0, 1));
      r1 = bus.req[1] | 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      if (!bus.req[0]) cur_a0 = $urandom;
      if (!bus.req[1]) cur_a1 = $urandom;
      xfer(r0, r1, cur_a0, cur_a1, 0, -1, -1, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2 && bus.req != 2'b00; i++)
      xfer(bus.req[0], bus.req[1], cur_a0, cur_a1, 0, -1, -1, 0);
`ifdef SD_READ_TIMEOUT_EN
    cur_a0 = 32'h0000_5000;
    xfer(1, 0, cur_a0, cur_a1, 0, -1, 10, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
